// File: rtl/timer_link_pkg.sv
// rtl/timer_link_pkg.sv - shared types and constants for the serial timer-command link
package timer_link_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT_DONE,
        ST_ACK,
        ST_GAP
    } link_state_t;

    localparam logic [3:0] PATTERN_DEFAULT = 4'b1101;
    localparam int         FRAME_LEN       = 8;
    localparam int         DELAY_W         = 4;

endpackage

// File: rtl/timer_link_tx_if.sv
// rtl/timer_link_tx_if.sv - command handshake and timer-status bundle for the link initiator
interface timer_link_tx_if #(
    parameter int CNT_W = 15
);
    import timer_link_pkg::*;

    logic               cmd_valid;
    logic [DELAY_W-1:0] cmd_delay;
    logic               cmd_ready;
    logic               data;
    logic               counting;
    logic               done;
    logic               ack;
    logic               busy;
    logic [CNT_W-1:0]   meas_count;
    logic               meas_valid;
    logic               timeout;

    modport slave (
        input  cmd_valid, cmd_delay, counting, done,
        output cmd_ready, data, ack, busy, meas_count, meas_valid, timeout
    );

    modport master (
        output cmd_valid, cmd_delay, counting, done,
        input  cmd_ready, data, ack, busy, meas_count, meas_valid, timeout
    );

endinterface

// File: rtl/timer_link_piso.sv
// rtl/timer_link_piso.sv - frame shifter, MSB first, zero-filled so the line idles low once drained
module timer_link_piso
    import timer_link_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 shift,
    input  logic [FRAME_LEN-1:0] load_data,
    output logic                 sdata,
    output logic                 last_bit
);

    localparam int BW = $clog2(FRAME_LEN);

    logic [FRAME_LEN-1:0] shreg;
    logic [BW-1:0]        bit_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (load) begin
            shreg   <= load_data;
            bit_cnt <= '0;
        end else if (shift) begin
            shreg   <= {shreg[FRAME_LEN-2:0], 1'b0};
            bit_cnt <= bit_cnt + BW'(1);
        end
    end

    assign sdata    = shreg[FRAME_LEN-1];
    assign last_bit = (bit_cnt == BW'(FRAME_LEN - 1));

endmodule

// File: rtl/timer_link_tx.sv
// rtl/timer_link_tx.sv - link initiator: serialises a delay command, then measures and supervises the remote timer
module timer_link_tx
    import timer_link_pkg::*;
#(
    parameter logic [3:0] PATTERN        = PATTERN_DEFAULT,
    parameter int         TIMEOUT_CYCLES = 20000,
    parameter int         GAP_CYCLES     = 4,
    parameter int         CNT_W          = 15
) (
    input logic            clk,
    input logic            reset,
    timer_link_tx_if.slave bus
);

    link_state_t      state, state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] meas_cnt;
    logic [CNT_W-1:0] meas_cnt_upd;
    logic [CNT_W-1:0] meas_count_r;
    logic             piso_load, piso_shift, piso_last, piso_sdata;
    logic             done_hit, timeout_hit;
    logic             ack_r, timeout_r;

    timer_link_piso u_piso (
        .clk       (clk),
        .reset     (reset),
        .load      (piso_load),
        .shift     (piso_shift),
        .load_data ({PATTERN, bus.cmd_delay}),
        .sdata     (piso_sdata),
        .last_bit  (piso_last)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // done is only looked at in WAIT_DONE and takes priority over the timeout limit
    always_comb begin
        state_next  = state;
        piso_load   = 1'b0;
        piso_shift  = 1'b0;
        done_hit    = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    piso_load  = 1'b1;
                    state_next = ST_SEND;
                end
            end
            ST_SEND: begin
                piso_shift = 1'b1;
                if (piso_last) state_next = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (bus.done) begin
                    done_hit   = 1'b1;
                    state_next = ST_ACK;
                end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    timeout_hit = 1'b1;
                    state_next  = ST_GAP;
                end
            end
            ST_ACK:  state_next = ST_GAP;
            ST_GAP: begin
                if (cnt == CNT_W'(GAP_CYCLES - 1)) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // one counter serves both the WAIT_DONE wait and the GAP length; it restarts on every state change
    always_ff @(posedge clk) begin
        if (reset || state == ST_IDLE || state_next != state) cnt <= '0;
        else                                                  cnt <= cnt + CNT_W'(1);
    end

    assign meas_cnt_upd = (bus.counting && meas_cnt != {CNT_W{1'b1}}) ? meas_cnt + CNT_W'(1) : meas_cnt;

    always_ff @(posedge clk) begin
        if (reset || state != ST_WAIT_DONE) meas_cnt <= '0;
        else                                meas_cnt <= meas_cnt_upd;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            meas_count_r <= '0;
            ack_r        <= 1'b0;
            timeout_r    <= 1'b0;
        end else begin
            if (done_hit) meas_count_r <= meas_cnt_upd;
            ack_r     <= done_hit;
            timeout_r <= timeout_hit;
        end
    end

    assign bus.data       = piso_sdata;
    assign bus.ack        = ack_r;
    assign bus.meas_valid = ack_r;
    assign bus.timeout    = timeout_r;
    assign bus.meas_count = meas_count_r;
    assign bus.cmd_ready  = (state == ST_IDLE);
    assign bus.busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_timer_link_tx.sv
// tb/tb_timer_link_tx.sv - self-checking bench for timer_link_tx with a behavioural remote-timer model
module tb_timer_link_tx;

    localparam int         TIMEOUT_CYCLES = 20000;
    localparam int         GAP_CYCLES     = 4;
    localparam int         CNT_W          = 15;
    localparam logic [3:0] PAT            = 4'b1101;
    localparam int         MEAS_MAX       = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;
    logic [CNT_W-1:0] exp_meas;

    always #5 clk = ~clk;

    timer_link_tx_if #(.CNT_W(CNT_W)) bus ();

    timer_link_tx #(
        .PATTERN        (PAT),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .GAP_CYCLES     (GAP_CYCLES),
        .CNT_W          (CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one command and checks the 8 serial bits; returns just after E8 (first WAIT_DONE cycle).
    task automatic send_frame(input logic [3:0] d, input logic done_lvl, input string tag);
        logic [7:0] got;
        logic [7:0] exp_frame;
        logic       bad_ack;
        exp_frame = 8'(int'(PAT) * 16 + int'(d));
        checks++;
        if (bus.cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s ready_before_cmd got=%b exp=1", tag, bus.cmd_ready);
        end
        bus.cmd_valid = 1'b1;
        bus.cmd_delay = d;
        bus.done      = done_lvl;
        step();
        bus.cmd_valid = 1'b0;
        got     = '0;
        got[7]  = bus.data;
        bad_ack = bus.ack;
        checks++;
        if (bus.cmd_ready !== 1'b0 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL %s ready_busy_after_accept got=%b%b exp=01", tag, bus.cmd_ready, bus.busy);
        end
        for (int i = 1; i < 8; i++) begin
            bus.cmd_delay = 4'($urandom);
            step();
            got[7-i] = bus.data;
            bad_ack  = bad_ack | bus.ack;
        end
        checks++;
        if (got !== exp_frame) begin
            failures++;
            $display("FAIL %s frame_bits got=%b exp=%b", tag, got, exp_frame);
        end
        step();
        bad_ack  = bad_ack | bus.ack;
        bus.done = 1'b0;
        checks++;
        if (bus.data !== 1'b0 || bad_ack !== 1'b0) begin
            failures++;
            $display("FAIL %s data_after_frame_or_ack got=%b,%b exp=0,0", tag, bus.data, bad_ack);
        end
    endtask

    // Called just after the edge that entered GAP; cmd_ready must rise exactly GAP_CYCLES edges later.
    task automatic gap_check(input logic done_lvl, input string tag);
        logic bad;
        bad = 1'b0;
        for (int k = 1; k <= GAP_CYCLES; k++) begin
            bus.done = done_lvl;
            step();
            if (bus.cmd_ready !== (k == GAP_CYCLES)) bad = 1'b1;
            if (bus.ack !== 1'b0 || bus.timeout !== 1'b0) bad = 1'b1;
        end
        bus.done = 1'b0;
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL %s gap_ready_timing got=%b exp=1 at gap end, no ack/timeout", tag, bus.cmd_ready);
        end
    endtask

    // Remote timer: counts for (d+1)*1000 cycles, then raises done until it sees ack.
    task automatic run_timer(input logic [3:0] d, input string tag);
        int   pre, post, n;
        logic saw;
        pre  = $urandom_range(0, 5);
        post = $urandom_range(1, 5);
        n    = (int'(d) + 1) * 1000;
        saw  = 1'b0;
        for (int i = 0; i < pre; i++) begin
            bus.counting = 1'b0; step(); saw = saw | bus.ack | bus.timeout;
        end
        for (int i = 0; i < n; i++) begin
            bus.counting = 1'b1; step(); saw = saw | bus.ack | bus.timeout;
        end
        for (int i = 0; i < post; i++) begin
            bus.counting = 1'b0; step(); saw = saw | bus.ack | bus.timeout;
        end
        checks++;
        if (saw !== 1'b0) begin
            failures++;
            $display("FAIL %s early_ack_or_timeout got=%b exp=0", tag, saw);
        end
        bus.done = 1'b1;
        step();
        exp_meas = (n > MEAS_MAX) ? CNT_W'(MEAS_MAX) : CNT_W'(n);
        checks++;
        if (bus.ack !== 1'b1 || bus.meas_valid !== 1'b1 || bus.timeout !== 1'b0) begin
            failures++;
            $display("FAIL %s ack_mv_to_at_done got=%b%b%b exp=110", tag, bus.ack, bus.meas_valid, bus.timeout);
        end
        checks++;
        if (bus.meas_count !== exp_meas) begin
            failures++;
            $display("FAIL %s meas_count got=%0d exp=%0d", tag, bus.meas_count, exp_meas);
        end
        bus.done = 1'b0;
        step();
        checks++;
        if (bus.ack !== 1'b0 || bus.meas_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s ack_single_cycle got=%b%b exp=00", tag, bus.ack, bus.meas_valid);
        end
        gap_check(1'b0, tag);
    endtask

    task automatic test_reset();
        checks++;
        if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0 || bus.data !== 1'b0) begin
            failures++;
            $display("FAIL reset ready_busy_data got=%b%b%b exp=100", bus.cmd_ready, bus.busy, bus.data);
        end
        checks++;
        if (bus.ack !== 1'b0 || bus.meas_valid !== 1'b0 || bus.timeout !== 1'b0 || bus.meas_count !== '0) begin
            failures++;
            $display("FAIL reset pulses_meas got=%b%b%b,%0d exp=000,0",
                     bus.ack, bus.meas_valid, bus.timeout, bus.meas_count);
        end
        exp_meas = '0;
    endtask

    task automatic test_basic();
        send_frame(4'd3, 1'b0, "basic_d3");
        run_timer(4'd3, "basic_d3");
    endtask

    task automatic test_long();
        send_frame(4'd15, 1'b0, "long_d15");
        run_timer(4'd15, "long_d15");
    endtask

    task automatic test_timeout();
        logic [3:0] d;
        logic       bad;
        d   = 4'($urandom);
        bad = 1'b0;
        send_frame(d, 1'b0, "timeout");
        for (int i = 1; i < TIMEOUT_CYCLES; i++) begin
            bus.counting = 1'($urandom);
            step();
            bad = bad | bus.timeout | bus.ack;
        end
        bus.counting = 1'b0;
        checks++;
        if (bad !== 1'b0) begin
            failures++;
            $display("FAIL timeout early_pulse got=%b exp=0", bad);
        end
        step();
        checks++;
        if (bus.timeout !== 1'b1 || bus.ack !== 1'b0) begin
            failures++;
            $display("FAIL timeout pulse_at_limit got=%b%b exp=10", bus.timeout, bus.ack);
        end
        checks++;
        if (bus.meas_count !== exp_meas) begin
            failures++;
            $display("FAIL timeout meas_hold got=%0d exp=%0d", bus.meas_count, exp_meas);
        end
        gap_check(1'b0, "timeout");
    endtask

    task automatic test_done_ignored_and_final();
        logic [3:0] d;
        int         ones;
        logic       c;
        d    = 4'($urandom);
        ones = 0;
        send_frame(d, 1'b1, "done_final");
        for (int i = 1; i < TIMEOUT_CYCLES; i++) begin
            c            = 1'($urandom);
            bus.counting = c;
            if (c) ones++;
            step();
        end
        bus.counting = 1'b0;
        bus.done     = 1'b1;
        step();
        exp_meas = (ones > MEAS_MAX) ? CNT_W'(MEAS_MAX) : CNT_W'(ones);
        checks++;
        if (bus.ack !== 1'b1 || bus.timeout !== 1'b0) begin
            failures++;
            $display("FAIL done_final done_beats_timeout got=%b%b exp=10", bus.ack, bus.timeout);
        end
        checks++;
        if (bus.meas_count !== exp_meas) begin
            failures++;
            $display("FAIL done_final meas_count got=%0d exp=%0d", bus.meas_count, exp_meas);
        end
        step();
        checks++;
        if (bus.ack !== 1'b0 || bus.meas_valid !== 1'b0) begin
            failures++;
            $display("FAIL done_final ack_with_done_held got=%b%b exp=00", bus.ack, bus.meas_valid);
        end
        gap_check(1'b1, "done_final");
    endtask

    task automatic test_reset_mid_send();
        bus.cmd_valid = 1'b1;
        bus.cmd_delay = 4'($urandom);
        step();
        bus.cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        reset = 1'b1;
        step();
        checks++;
        if (bus.data !== 1'b0 || bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL mid_send_reset data_ready_busy got=%b%b%b exp=010", bus.data, bus.cmd_ready, bus.busy);
        end
        checks++;
        if (bus.meas_count !== '0) begin
            failures++;
            $display("FAIL mid_send_reset meas_count got=%0d exp=0", bus.meas_count);
        end
        exp_meas = '0;
        reset    = 1'b0;
        send_frame(4'd0, 1'b0, "after_reset_d0");
        run_timer(4'd0, "after_reset_d0");
    endtask

    task automatic test_back_to_back();
        logic [3:0] d;
        for (int t = 0; t < 3; t++) begin
            d = 4'($urandom_range(0, 2));
            send_frame(d, 1'b0, "b2b");
            run_timer(d, "b2b");
        end
    endtask

    initial begin
        reset         = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_delay = 4'd0;
        bus.counting  = 1'b0;
        bus.done      = 1'b0;
        step();
        step();
        reset = 1'b0;
        test_reset();
        test_basic();
        test_long();
        test_timeout();
        test_done_ignored_and_final();
        test_reset_mid_send();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/timer_link_tx.md
# timer_link_tx

Initiator end of the serial timer-command link. Accepts a 4-bit delay command on a valid/ready handshake, serialises it onto `data` as the 1101 start pattern followed by the delay (MSB first), then supervises the remote timer: it measures how long `counting` stays high, acknowledges `done`, and aborts with a timeout if `done` never arrives. Sits in the control fabric between the command source and the remote delay timer.

## Interface
- `PATTERN`, 4'b1101, start pattern, sent MSB first
- `TIMEOUT_CYCLES`, 20000, max cycles in WAIT_DONE before abort (must exceed 16000)
- `GAP_CYCLES`, 4, cycles of `data`=0 forced after each transaction, ≥1
- `CNT_W`, 15, width of wait/measure counters; must hold TIMEOUT_CYCLES
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high; clock clk
- `cmd_valid`  in  1  command request
- `cmd_delay`  in  4  delay code; remote timer runs (cmd_delay+1)*1000 cycles
- `cmd_ready`  out  1  high in IDLE only
- `data`  out  1  serial line to timer, registered
- `counting`  in  1  timer status: counting
- `done`  in  1  timer status: expired, held until ack
- `ack`  out  1  one-cycle acknowledge to timer, registered
- `busy`  out  1  high in any state except IDLE
- `meas_count`  out  CNT_W  cycles `counting` was high in last completed transaction
- `meas_valid`  out  1  one-cycle pulse, coincident with `ack`
- `timeout`  out  1  one-cycle pulse on abort

## Operation
- States: IDLE, SEND (8 bits), WAIT_DONE, ACK, GAP.
- IDLE: `data`=0, `cmd_ready`=1. On `cmd_valid && cmd_ready` at edge E0: load shifter with {PATTERN, cmd_delay}, bit counter 0, go SEND.
- SEND: `data` = shifter MSB; shift left each edge; after 8th bit go WAIT_DONE, `data`=0. `cmd_delay` changes after E0 ignored.
- WAIT_DONE: wait counter from 0, +1 per cycle; meas counter from 0, +1 per cycle with `counting`=1, saturating at 2^CNT_W−1.
  - `done`=1 sampled: go ACK, latch meas counter into `meas_count`.
  - Else if wait counter == TIMEOUT_CYCLES−1: pulse `timeout`, go GAP, `meas_count` unchanged.
  - `done` and timeout limit on same edge: `done` wins.
- ACK: `ack`=1, `meas_valid`=1 exactly one cycle; go GAP.
- GAP: `data`=0, `cmd_ready`=0 for GAP_CYCLES cycles, then IDLE. `done` ignored in SEND, ACK, GAP.
- Reset (any time, incl. mid-SEND): next edge state IDLE, `data`=0, `ack`=0, `meas_valid`=0, `timeout`=0, `meas_count`=0, counters 0; `cmd_ready`=1, `busy`=0.

## Timing
- Accept at E0: `data` = PATTERN[3] after E0, PATTERN[2] after E1, … `cmd_delay[0]` after E7; receiver samples edges E1–E8.
- E8: `data`=0, WAIT_DONE entered; wait counter 0 during first WAIT_DONE cycle.
- `done` first seen at edge Ed: `ack`/`meas_valid` high Ed..Ed+1; GAP Ed+1..Ed+1+GAP_CYCLES; `cmd_ready` high after Ed+1+GAP_CYCLES.
- Timeout: `timeout` high for the cycle after edge where wait counter == TIMEOUT_CYCLES−1; no `ack`.
- Back-to-back commands: minimum spacing 8 + WAIT_DONE + 1 + GAP_CYCLES cycles.

## Structure
- Package `timer_link_pkg`: state enum, `PATTERN` default, frame length constant (8), delay-code width (4); shared with the receiver side and bench.
- Sub-module `timer_link_piso`: 8-bit load/shift parallel-in-serial-out with bit counter and `last_bit` flag. FSM, counters, measure latch in top.

## Test plan
- Reset, then `cmd_delay`=3 -> `data` on E1–E8 = 1,1,0,1,0,0,1,1; `cmd_ready`=0 from E0+1.
- Timer model (`counting` 4000 cycles, then `done`) for delay 3 -> single-cycle `ack`, `meas_valid`, `meas_count`=4000; `cmd_ready` again GAP_CYCLES+1 cycles after `done` seen.
- `cmd_delay`=15, model 16000 counting cycles -> `meas_count`=16000, no `timeout`.
- `done` never asserted -> `timeout` pulse exactly TIMEOUT_CYCLES cycles after WAIT_DONE entry, no `ack`, `meas_count` holds prior value.
- `done` asserted during SEND and GAP -> no `ack`; `done` on final timeout cycle -> `ack`, no `timeout`.
- Reset asserted after 5th SEND bit -> `data`=0, `cmd_ready`=1 next cycle; fresh command 0 sends 1,1,0,1,0,0,0,0.
